// File: rtl/wbcon_pkg.sv
// Shared definitions for the packet arbiter: FSM encoding and stream width.
package wbcon_pkg;

  localparam logic STATE_IDLE    = 1'b0;
  localparam logic STATE_GRANTED = 1'b1;

  typedef enum logic {
    ST_IDLE    = STATE_IDLE,
    ST_GRANTED = STATE_GRANTED
  } arb_state_e;

  localparam int DATA_W = 8;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry skid buffer for a byte stream with last; every output is a flop,
// and the upstream ready depends only on the skid-entry occupancy.
module axis_skid_buf
  import wbcon_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_s_tvalid,
  output logic              o_s_tready,
  input  logic [DATA_W-1:0] i_s_tdata,
  input  logic              i_s_tlast,
  output logic              o_m_tvalid,
  input  logic              i_m_tready,
  output logic [DATA_W-1:0] o_m_tdata,
  output logic              o_m_tlast
);

  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic              skid_last;

  assign o_s_tready = ~skid_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_m_tvalid <= 1'b0;
      o_m_tdata  <= '0;
      o_m_tlast  <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_last  <= 1'b0;
    end else if (!o_m_tvalid || i_m_tready) begin
      // Output register is free this cycle: refill from skid first to keep order.
      if (skid_valid) begin
        o_m_tdata  <= skid_data;
        o_m_tlast  <= skid_last;
        skid_valid <= 1'b0;
      end else if (i_s_tvalid) begin
        o_m_tvalid <= 1'b1;
        o_m_tdata  <= i_s_tdata;
        o_m_tlast  <= i_s_tlast;
      end else begin
        o_m_tvalid <= 1'b0;
      end
    end else if (i_s_tvalid && !skid_valid) begin
      skid_valid <= 1'b1;
      skid_data  <= i_s_tdata;
      skid_last  <= i_s_tlast;
    end
  end

endmodule

// File: rtl/axis_pkt_arb.sv
// Round-robin packet arbiter merging NUM_SRC byte streams into one, holding
// each grant until the source's tlast beat is accepted.
//
// state   | meaning
// IDLE    | no grant; pick next requester round-robin from last_grant+1
// GRANTED | one source owns the output until its tlast beat is accepted
module axis_pkt_arb
  import wbcon_pkg::*;
#(
  parameter int NUM_SRC = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NUM_SRC-1:0]    i_s_axis_tvalid,
  output logic [NUM_SRC-1:0]    o_s_axis_tready,
  input  logic [8*NUM_SRC-1:0]  i_s_axis_tdata,
  input  logic [NUM_SRC-1:0]    i_s_axis_tlast,
  output logic                  o_m_axis_tvalid,
  input  logic                  i_m_axis_tready,
  output logic [7:0]            o_m_axis_tdata,
  output logic                  o_m_axis_tlast,
  output logic [NUM_SRC-1:0]    o_grant
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  arb_state_e        state;
  logic [IDX_W-1:0]  cur_idx;
  logic [IDX_W-1:0]  last_grant;
  logic [IDX_W-1:0]  pick_idx;
  logic              skid_ready;
  logic              sel_valid;
  logic              sel_last;
  logic [7:0]        sel_data;
  logic              accept;

  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                               input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    pick = last;
    // Walk from farthest to nearest so the closest requester after last wins.
    for (int i = NUM_SRC; i >= 1; i--) begin
      cand = IDX_W'((int'(last) + i) % NUM_SRC);
      if (req[cand]) pick = cand;
    end
    return pick;
  endfunction

  assign pick_idx = rr_pick(i_s_axis_tvalid, last_grant);

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (cur_idx == IDX_W'(k)) begin
        sel_valid = i_s_axis_tvalid[k];
        sel_last  = i_s_axis_tlast[k];
        sel_data  = i_s_axis_tdata[8*k +: 8];
      end
    end
  end

  assign accept          = (state == ST_GRANTED) && skid_ready && sel_valid;
  assign o_s_axis_tready = o_grant & {NUM_SRC{skid_ready}};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      o_grant    <= '0;
      cur_idx    <= '0;
      last_grant <= IDX_W'(NUM_SRC - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (|i_s_axis_tvalid) begin
            cur_idx <= pick_idx;
            o_grant <= NUM_SRC'(1) << pick_idx;
            state   <= ST_GRANTED;
          end
        end
        ST_GRANTED: begin
          if (accept && sel_last) begin
            last_grant <= cur_idx;
            o_grant    <= '0;
            state      <= ST_IDLE;
          end
        end
      endcase
    end
  end

  axis_skid_buf u_skid (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_s_tvalid (accept),
    .o_s_tready (skid_ready),
    .i_s_tdata  (sel_data),
    .i_s_tlast  (sel_last),
    .o_m_tvalid (o_m_axis_tvalid),
    .i_m_tready (i_m_axis_tready),
    .o_m_tdata  (o_m_axis_tdata),
    .o_m_tlast  (o_m_axis_tlast)
  );

endmodule

// File: doc/axis_pkt_arb.md
AXIS_PKT_ARB -- requirements
Module: axis_pkt_arb

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2, number of byte-stream sources (range 1..8).
REQ-002 SHALL have port i_clk, input, 1, single clock; all logic on posedge.
REQ-003 SHALL have port i_rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port i_s_axis_tvalid, input, NUM_SRC, per-source beat valid.
REQ-005 SHALL have port o_s_axis_tready, output, NUM_SRC, per-source beat ready.
REQ-006 SHALL have port i_s_axis_tdata, input, 8*NUM_SRC, per-source byte; source k occupies bits [8k+7:8k].
REQ-007 SHALL have port i_s_axis_tlast, input, NUM_SRC, per-source end-of-packet.
REQ-008 SHALL have port o_m_axis_tvalid, output, 1, merged stream valid.
REQ-009 SHALL have port i_m_axis_tready, input, 1, merged stream ready.
REQ-010 SHALL have port o_m_axis_tdata, output, 8, merged stream byte.
REQ-011 SHALL have port o_m_axis_tlast, output, 1, merged stream end-of-packet.
REQ-012 SHALL have port o_grant, output, NUM_SRC, one-hot registered grant; all-zero when idle.

Function
REQ-013 SHALL implement a two-state FSM: IDLE and GRANTED.
REQ-014 In IDLE with any i_s_axis_tvalid high, SHALL select the next requesting source round-robin, starting at last_grant+1 modulo NUM_SRC.
REQ-015 SHALL register the selection into o_grant and enter GRANTED at the end of that same cycle.
REQ-016 In IDLE, o_s_axis_tready SHALL be all-zero.
REQ-017 In GRANTED, o_s_axis_tready SHALL be high only for the granted source, and only when the output skid stage is not full.
REQ-018 A beat is accepted when the granted source's tvalid and tready are both high.
REQ-019 An accepted beat with tlast=1 SHALL update last_grant, clear o_grant and return the FSM to IDLE.
REQ-020 A beat accepted in cycle N SHALL appear on o_m_axis_* at cycle N+1.
REQ-021 Latency from source tvalid rising in IDLE (cycle 0) to o_m_axis_tvalid SHALL be 2 cycles: grant in cycle 0, accept in cycle 1, output in cycle 2.
REQ-022 Throughput within a packet SHALL be 1 beat/cycle when i_m_axis_tready=1.
REQ-023 Exactly one source-side idle cycle SHALL separate consecutive packets.
REQ-024 The output stage SHALL be a 2-entry skid buffer with registered tvalid, tdata and tlast.
REQ-025 o_s_axis_tready SHALL derive only from registers, with no combinational path from i_m_axis_tready.
REQ-026 Beats SHALL be neither dropped, duplicated nor reordered under any backpressure pattern.
REQ-027 While a source is granted, its packet SHALL NOT be interleaved with any other source's bytes.
REQ-028 If the granted source deasserts tvalid mid-packet, the grant SHALL be held indefinitely until a tlast beat is accepted.
REQ-029 A single-beat packet (tlast on the first beat) SHALL be handled with no extra cycles.
REQ-030 With NUM_SRC=1, the block SHALL behave identically, with o_grant toggling per packet.
REQ-031 o_m_axis_tvalid, once high, SHALL stay high with stable data until accepted.

Reset
REQ-032 Asserting i_rst_n low SHALL force IDLE, o_grant=0, o_s_axis_tready=0, o_m_axis_tvalid=0, o_m_axis_tdata=0, o_m_axis_tlast=0, empty skid buffer, and last_grant=NUM_SRC-1 so source 0 wins first.
REQ-033 Reset mid-packet SHALL discard buffered beats without emitting tlast; recovery is the sink's responsibility.
REQ-034 After deassertion, the first grant SHALL be possible in the first clock cycle.

Structure
REQ-035 The FSM state encoding SHALL be localparams in a shared package wbcon_pkg, with STATE_IDLE=1'b0 and STATE_GRANTED=1'b1.
REQ-036 The skid buffer SHALL be a separate sub-module, axis_skid_buf, with 8-bit data plus last and the same clock/reset ports.
REQ-037 Round-robin selection SHALL be a combinational function local to axis_pkt_arb.

Verification
REQ-038 Single source: src0 sends 3-byte packet 83,AA,01 with m_tready=1 -> output 83,AA,01 at cycles 2,3,4; tlast only on 01; o_grant=01 in cycles 1..3.
REQ-039 Contention: src0 and src1 both hold 2-byte packets continuously -> packets alternate src0,src1,src0; no byte interleaving; one source-side gap between packets.
REQ-040 Backpressure: random 50% m_tready over a 16-byte packet -> all 16 bytes output in order; o_m_axis_tvalid/tdata stable while stalled.
REQ-041 Mid-packet stall: src1 granted, tvalid drops 5 cycles after byte 1 while src0 requests -> grant stays on src1 until its tlast; src0 granted next.
REQ-042 Reset mid-packet: assert i_rst_n=0 after byte 2 of 4 -> all outputs 0 during reset; after release, next packet comes from source 0.
